graph: RTL and testbench
========================

// Module: graph
// PURPOSE
//  Generates a 64-point plot of y = A*x^2 + B*x + C on the equally spaced grid x_i = X0 + i*DX.
//  Results are two 64-entry coordinate banks (xs, ys) for a downstream plotter/display block.
//  Uses forward differences, so only adders are in the per-point loop (multipliers only at init).
//  Runs once after each reset release, then raises complete.
// PARAMETERS
//  X0  -32  signed 32b x of point 0
//  DX    1  signed 32b x step between points
//  A     1  signed 32b quadratic coefficient
//  B     0  signed 32b linear coefficient
//  C     0  signed 32b constant term
// PORTS
//  clk       in   1         single clock, rising edge
//  rst       in   1         asynchronous, active-high reset
//  xs        out  32 x[63:0] unpacked array; xs[i] = x of point i
//  ys        out  32 x[63:0] unpacked array; ys[i] = y of point i
//  complete  out  1         1 = all 64 points valid; held until next reset
// BEHAVIOUR
//  - Reset (async assert, sync release): all xs[i]=0, all ys[i]=0, complete=0, state=INIT, idx=0.
//  - Arithmetic: 32b two's complement; all sums/products wrap mod 2^32; no saturation or overflow flag.
//  - FSM:
//    - INIT (1 cycle): x<=X0; y<=A*X0*X0+B*X0+C; d<=A*(2*X0*DX+DX*DX)+B*DX; dd<=2*A*DX*DX. -> RUN.
//    - RUN (64 cycles): xs[idx]<=x, ys[idx]<=y; x<=x+DX; y<=y+d; d<=d+dd; idx<=idx+1.
//      After idx==63 is written -> DONE.
//    - DONE: complete<=1; arrays frozen; idle until reset.
//  - Timing after reset release:
//    - edge 1 = INIT.
//    - edges 2..65 write points 0..63, one per edge.
//    - complete is registered and reads 1 after edge 66.
//  - Entries not yet written keep 0. Readers use complete as the only valid qualifier.
//  - rst asserted mid-run: immediate clear of all outputs; restart from INIT on release.
//  - rst held high: outputs stay 0 indefinitely.
//  - idx is 7 bits so the terminal compare is unambiguous; no wrap past 63.
//  - Results must be bit-exact to the closed-form polynomial evaluated mod 2^32.
// STRUCTURE
//  - graph_pkg:
//    - N_POINTS=64, IDX_W=7.
//    - coord_t = logic signed [31:0].
//    - state_e {INIT, RUN, DONE}.
//  - Sub-module graph_fwd_diff: holds x/y/d/dd; has load and step inputs; outputs current x, y.
//  - Top holds FSM, idx counter, and the two register banks.
//  - Outputs come straight from flops (no combinational paths to ports).
// TESTING
//  - Defaults, reset then release:
//    - xs[0]=32'hFFFFFFE0, ys[0]=1024, ys[32]=0, xs[63]=31, ys[63]=961.
//    - complete first high after edge 66.
//  - A=0,B=3,C=5,X0=0,DX=2: ys[i]=6i+5, i.e. ys[0]=5, ys[63]=383.
//  - Overflow wrap, X0=65536,A=1,B=0,C=0,DX=1: ys[0]=0 (2^32 wraps).
//    Every ys[i] equals the mod-2^32 closed form.
//  - Reset asserted at edge 30 of RUN:
//    - all outputs 0 and complete=0 asynchronously.
//    - after release, identical final arrays to a clean run.
//  - rst held high 1000 cycles: complete=0, all entries 0.
//  - After complete: 900 further cycles with no change to any xs/ys entry.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared types and constants for the quadratic plot generator.
package graph_pkg;

  localparam int N_POINTS = 64;
  localparam int IDX_W    = 7;

  typedef logic signed [31:0] coord_t;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DONE
  } state_e;

  // Index of the last point; idx is one bit wider so this compare never aliases.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

endpackage

// File: rtl/graph_fwd_diff.sv
// Forward-difference evaluator for y = A*x^2 + B*x + C on x = X0 + i*DX.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      seed x, y, first difference d and constant second difference dd
//   step      advance one grid point (adders only)
//   x, y      current point, straight from flops
module graph_fwd_diff
  import graph_pkg::*;
#(
  parameter coord_t X0 = -32,
  parameter coord_t DX = 1,
  parameter coord_t A  = 1,
  parameter coord_t B  = 0,
  parameter coord_t C  = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   step,
  output coord_t x,
  output coord_t y
);

  // Seed values; all arithmetic is 32-bit and wraps mod 2^32.
  localparam coord_t TWO     = 2;
  localparam coord_t Y_INIT  = A * X0 * X0 + B * X0 + C;
  localparam coord_t D_INIT  = A * (TWO * X0 * DX + DX * DX) + B * DX;
  localparam coord_t DD_INIT = TWO * A * DX * DX;

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  coord_t d_q, d_d;
  coord_t dd_q, dd_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    d_d  = d_q;
    dd_d = dd_q;
    if (load) begin
      x_d  = X0;
      y_d  = Y_INIT;
      d_d  = D_INIT;
      dd_d = DD_INIT;
    end else if (step) begin
      x_d = x_q + DX;
      y_d = y_q + d_q;
      d_d = d_q + dd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      d_q  <= '0;
      dd_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      d_q  <= d_d;
      dd_q <= dd_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/graph.sv
// Quadratic plot generator: fills 64-entry xs/ys banks once after reset
// release, then raises complete.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; clears banks and complete
//   xs, ys    coordinate banks, entry i = point i (0 until written)
//   complete  1 once all points are valid, held until reset
//
// state | meaning
// INIT  | seed the forward-difference evaluator
// RUN   | write point idx, advance evaluator
// DONE  | banks frozen, complete asserted
module graph
  import graph_pkg::*;
#(
  parameter coord_t X0 = -32,
  parameter coord_t DX = 1,
  parameter coord_t A  = 1,
  parameter coord_t B  = 0,
  parameter coord_t C  = 0
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t xs [N_POINTS],
  output coord_t ys [N_POINTS],
  output logic   complete
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  coord_t             xs_q [N_POINTS];
  coord_t             xs_d [N_POINTS];
  coord_t             ys_q [N_POINTS];
  coord_t             ys_d [N_POINTS];
  logic               complete_q, complete_d;

  logic   load, step;
  coord_t cur_x, cur_y;

  graph_fwd_diff #(
    .X0 (X0),
    .DX (DX),
    .A  (A),
    .B  (B),
    .C  (C)
  ) u_fwd_diff (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .x    (cur_x),
    .y    (cur_y)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    xs_d       = xs_q;
    ys_d       = ys_q;
    complete_d = complete_q;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      INIT: begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step                    = 1'b1;
        xs_d[idx_q[IDX_W-2:0]]  = cur_x;
        ys_d[idx_q[IDX_W-2:0]]  = cur_y;
        idx_d                   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        complete_d = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      idx_q      <= '0;
      complete_q <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) begin
        xs_q[i] <= '0;
        ys_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      complete_q <= complete_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
    end
  end

  assign xs       = xs_q;
  assign ys       = ys_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_graph.sv
// Bench for graph: three parameterisations share one clock/reset. A closed-form
// model (point i written at edge i+2 after release, complete from edge 66)
// is compared against every output on every falling edge.
module tb_graph;
  import graph_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  coord_t d_xs [N_POINTS];
  coord_t d_ys [N_POINTS];
  logic   d_comp;
  coord_t l_xs [N_POINTS];
  coord_t l_ys [N_POINTS];
  logic   l_comp;
  coord_t o_xs [N_POINTS];
  coord_t o_ys [N_POINTS];
  logic   o_comp;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  always #5 clk = ~clk;

  graph u_dflt (
    .clk(clk), .rst(rst), .xs(d_xs), .ys(d_ys), .complete(d_comp)
  );

  graph #(.X0(0), .DX(2), .A(0), .B(3), .C(5)) u_lin (
    .clk(clk), .rst(rst), .xs(l_xs), .ys(l_ys), .complete(l_comp)
  );

  graph #(.X0(65536), .DX(1), .A(1), .B(0), .C(0)) u_ovf (
    .clk(clk), .rst(rst), .xs(o_xs), .ys(o_ys), .complete(o_comp)
  );

  // Edges since reset release; cleared the instant rst rises.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] poly(input longint a, input longint b,
                                       input longint c, input longint x);
    longint r;
    r = a * x * x + b * x + c;
    return r[31:0];
  endfunction

  function automatic logic [31:0] xat(input longint x0, input longint dx, input int i);
    longint r;
    r = x0 + dx * i;
    return r[31:0];
  endfunction

  task automatic cmp_inst(input string tag, input longint x0, input longint dx,
                          input longint a, input longint b, input longint c,
                          input coord_t xs_a [N_POINTS], input coord_t ys_a [N_POINTS],
                          input logic comp, input int e);
    logic [31:0] ex, ey;
    chk($sformatf("%s.complete@%0d", tag, e), {31'b0, comp}, {31'b0, (e >= 66)});
    for (int i = 0; i < N_POINTS; i++) begin
      if (i <= e - 2) begin
        ex = xat(x0, dx, i);
        ey = poly(a, b, c, {{32{ex[31]}}, ex});
      end else begin
        ex = '0;
        ey = '0;
      end
      chk($sformatf("%s.xs[%0d]@%0d", tag, i, e), xs_a[i], ex);
      chk($sformatf("%s.ys[%0d]@%0d", tag, i, e), ys_a[i], ey);
    end
  endtask

  always @(negedge clk) begin
    cmp_inst("dflt", -32, 1, 1, 0, 0, d_xs, d_ys, d_comp, edges);
    cmp_inst("lin", 0, 2, 0, 3, 5, l_xs, l_ys, l_comp, edges);
    cmp_inst("ovf", 65536, 1, 1, 0, 0, o_xs, o_ys, o_comp, edges);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_complete(input string name);
    int n;
    n = 0;
    while (!(d_comp && l_comp && o_comp) && n < 200) begin
      tick();
      n++;
    end
    if (!(d_comp && l_comp && o_comp)) chk({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ".complete"}, {31'b0, d_comp | l_comp | o_comp}, 32'd0);
    for (int i = 0; i < N_POINTS; i++) begin
      chk($sformatf("%s.dxs[%0d]", name, i), d_xs[i], 32'd0);
      chk($sformatf("%s.dys[%0d]", name, i), d_ys[i], 32'd0);
      chk($sformatf("%s.lys[%0d]", name, i), l_ys[i], 32'd0);
      chk($sformatf("%s.oys[%0d]", name, i), o_ys[i], 32'd0);
    end
  endtask

  task automatic check_literals(input string name);
    chk({name, ".dflt.xs0"},  d_xs[0],  32'hFFFFFFE0);
    chk({name, ".dflt.ys0"},  d_ys[0],  32'd1024);
    chk({name, ".dflt.ys32"}, d_ys[32], 32'd0);
    chk({name, ".dflt.xs63"}, d_xs[63], 32'd31);
    chk({name, ".dflt.ys63"}, d_ys[63], 32'd961);
    chk({name, ".lin.ys0"},   l_ys[0],  32'd5);
    chk({name, ".lin.ys63"},  l_ys[63], 32'd383);
    chk({name, ".lin.xs63"},  l_xs[63], 32'd126);
    chk({name, ".ovf.ys0"},   o_ys[0],  32'd0);
    chk({name, ".ovf.ys1"},   o_ys[1],  32'd131073);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");

    // Clean run; complete must be low through edge 65 and high after edge 66.
    rst = 1'b0;
    while (edges < 65) tick();
    chk("complete_at_65", {31'b0, d_comp}, 32'd0);
    tick();
    chk("complete_at_66", {31'b0, d_comp}, 32'd1);
    wait_complete("run1");
    check_literals("run1");
    repeat (900) tick();
    check_literals("frozen");

    // Mid-run reset at RUN edge 30: outputs clear without waiting for a clock.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (edges < 31 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_edge31", {31'b0, edges >= 31}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_clear");
    repeat (2) tick();
    rst = 1'b0;
    wait_complete("run2");
    check_literals("run2");

    // Reset held: model demands all-zero every cycle.
    rst = 1'b1;
    repeat (1000) tick();
    check_all_zero("held");

    rst = 1'b0;
    wait_complete("run3");
    check_literals("run3");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
